mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between an
// instruction-fetch requester and a data load/store requester.
module mem_arbiter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [7:0]  d_wmask,
  output logic        d_ack,
  output logic [63:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [63:0] mem_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic       OWN_FETCH = 1'b0;
  localparam logic       OWN_DATA  = 1'b1;
  localparam logic [1:0] CNT_LAST  = 2'(MEM_LATENCY - 1);

  state_t      state, state_nxt;
  logic        last_grant;
  logic        owner;
  logic        grant_data;
  logic        any_req;
  logic        capture;
  logic [1:0]  cnt;
  logic [31:0] addr_q;
  logic        we_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;

  assign any_req    = if_req | d_req;
  // On a tie the side that did not win last time gets the port.
  assign grant_data = d_req & (~if_req | (last_grant == OWN_FETCH));
  assign capture    = (state == WAIT) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      last_grant <= OWN_FETCH;
      owner      <= OWN_FETCH;
      cnt        <= 2'd0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == WAIT && !capture) ? cnt + 2'd1 : 2'd0;
      if (state == IDLE && any_req) begin
        owner      <= grant_data;
        last_grant <= grant_data;
        addr_q     <= grant_data ? d_addr : if_addr;
        we_q       <= grant_data & d_we;
        // Only stores carry write data/mask onto the memory bus.
        wdata_q    <= (grant_data && d_we) ? d_wdata : '0;
        wmask_q    <= (grant_data && d_we) ? d_wmask : '0;
      end
      if (capture) begin
        if (owner == OWN_FETCH)
          if_rdata <= addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
        else if (!we_q)
          d_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wmask = '0;
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    case (state)
      IDLE:  if (any_req) state_nxt = ISSUE;
      ISSUE: begin
        state_nxt = WAIT;
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_wmask = wmask_q;
      end
      WAIT:  if (capture) state_nxt = RESP;
      RESP:  begin
        state_nxt = IDLE;
        if_ack    = (owner == OWN_FETCH);
        d_ack     = (owner == OWN_DATA);
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (latency 1 and 3) share stimulus and are
// checked every cycle against a transaction-timing reference model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst, if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr;
  logic [63:0] d_wdata, mem_rdata;
  logic [7:0]  d_wmask;

  logic        if_ack_o[2], d_ack_o[2], mem_en_o[2], mem_we_o[2], busy_o[2];
  logic [31:0] if_rdata_o[2], mem_addr_o[2];
  logic [63:0] d_rdata_o[2], mem_wdata_o[2];
  logic [7:0]  mem_wmask_o[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.MEM_LATENCY(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .nrst(nrst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_o[g]), .if_rdata(if_rdata_o[g]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
      .d_ack(d_ack_o[g]), .d_rdata(d_rdata_o[g]),
      .mem_en(mem_en_o[g]), .mem_we(mem_we_o[g]), .mem_addr(mem_addr_o[g]),
      .mem_wdata(mem_wdata_o[g]), .mem_wmask(mem_wmask_o[g]), .mem_rdata(mem_rdata),
      .busy(busy_o[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_on = 0;
  bit rand_mem = 0;

  function automatic int lat(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(string name, int i, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[L=%0d] cyc=%0d: got %h want %h", name, lat(i), cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mem) mem_rdata = {$urandom, $urandom};
  endtask

  // Reference model: a transaction granted in cycle g issues in g+1, samples
  // memory in g+1+L, acks in g+2+L and the port is free again in g+3+L.
  bit          m_act[2]  = '{0, 0};
  int          m_g[2]    = '{0, 0};
  bit          m_own[2]  = '{0, 0};
  bit          m_we[2]   = '{0, 0};
  bit          m_last[2] = '{0, 0};
  logic [31:0] m_addr[2] = '{0, 0};
  logic [63:0] m_wd[2]   = '{0, 0};
  logic [7:0]  m_msk[2]  = '{0, 0};
  logic [31:0] m_ifr[2]  = '{0, 0};
  logic [63:0] m_dr[2]   = '{0, 0};
  int          ph, lm;
  bit          iss, rsp, win_d;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      lm  = lat(i);
      ph  = cyc - m_g[i];
      iss = m_act[i] && ph == 1;
      rsp = m_act[i] && ph == lm + 2;
      if (chk_on) begin
        chk("busy", i, busy_o[i], m_act[i]);
        chk("mem_en", i, mem_en_o[i], iss);
        chk("mem_we", i, mem_we_o[i], iss && m_we[i]);
        chk("mem_wmask", i, mem_wmask_o[i], iss ? m_msk[i] : 8'h0);
        chk("mem_addr", i, mem_addr_o[i], m_addr[i]);
        chk("mem_wdata", i, mem_wdata_o[i], m_wd[i]);
        chk("if_ack", i, if_ack_o[i], rsp && !m_own[i]);
        chk("d_ack", i, d_ack_o[i], rsp && m_own[i]);
        chk("if_rdata", i, if_rdata_o[i], m_ifr[i]);
        chk("d_rdata", i, d_rdata_o[i], m_dr[i]);
      end
      if (!nrst) begin
        m_act[i] = 0; m_last[i] = 0; m_own[i] = 0; m_we[i] = 0;
        m_addr[i] = 0; m_wd[i] = 0; m_msk[i] = 0; m_ifr[i] = 0; m_dr[i] = 0;
      end else if (m_act[i]) begin
        if (ph == lm + 1) begin
          if (!m_own[i]) m_ifr[i] = m_addr[i][2] ? mem_rdata[63:32] : mem_rdata[31:0];
          else if (!m_we[i]) m_dr[i] = mem_rdata;
        end
        if (ph == lm + 2) m_act[i] = 0;
      end else if (if_req || d_req) begin
        if (if_req && d_req) win_d = !m_last[i];
        else win_d = d_req;
        m_act[i]  = 1;
        m_g[i]    = cyc;
        m_own[i]  = win_d;
        m_last[i] = win_d;
        m_we[i]   = win_d && d_we;
        m_addr[i] = win_d ? d_addr : if_addr;
        m_wd[i]   = (win_d && d_we) ? d_wdata : 64'h0;
        m_msk[i]  = (win_d && d_we) ? d_wmask : 8'h0;
      end
    end
  end

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    logic [63:0] rdata;
    logic [31:0] exp_if;
    logic [63:0] exp_d;
    bit          exp_mwe;
    logic [7:0]  exp_msk;
    logic [63:0] exp_mwd;
  } vec_t;

  vec_t vecs[6];
  int   ack_at[2], iss_at[2], fack_at[2], n_ack[2], prev_k[2], exp_n;
  bit   prev_d[2], is_d_ack;
  int   coinc;

  initial begin
    vecs[0] = '{0, 0, 32'h4,   64'hBAD, 8'hFF, 64'hDEADBEEF_00000013, 32'hDEADBEEF, 64'h0, 0, 8'h0, 64'h0};
    vecs[1] = '{0, 0, 32'h3,   64'h0,   8'h0,  64'hCAFEF00D_12345678, 32'h12345678, 64'h0, 0, 8'h0, 64'h0};
    vecs[2] = '{1, 0, 32'h200, 64'h0,   8'h0,  64'h01234567_89ABCDEF, 32'h0, 64'h01234567_89ABCDEF, 0, 8'h0, 64'h0};
    vecs[3] = '{1, 1, 32'h100, 64'h11223344_55667788, 8'h0F, 64'hFFFFFFFF_FFFFFFFF, 32'h0,
                64'h01234567_89ABCDEF, 1, 8'h0F, 64'h11223344_55667788};
    vecs[4] = '{0, 0, 32'h6,   64'h0,   8'h0,  64'hA5A5A5A5_5A5A5A5A, 32'hA5A5A5A5, 64'h0, 0, 8'h0, 64'h0};
    vecs[5] = '{1, 0, 32'h208, 64'hFFFF, 8'hFF, 64'h0, 32'h0, 64'h0, 0, 8'h0, 64'h0};

    nrst = 0; if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0;
    d_wdata = 0; d_wmask = 0; mem_rdata = 0;
    tick();
    chk_on = 1;
    tick();
    nrst = 1;

    // Single transactions from the table, run on both latencies at once.
    for (int v = 0; v < 6; v++) begin
      if_req = !vecs[v].is_d; d_req = vecs[v].is_d; d_we = vecs[v].we;
      if_addr = vecs[v].addr; d_addr = vecs[v].addr;
      d_wdata = vecs[v].wdata; d_wmask = vecs[v].mask; mem_rdata = vecs[v].rdata;
      tick();
      if_req = 0; d_req = 0; if_addr = $urandom; d_addr = $urandom; d_we = 1;
      for (int i = 0; i < 2; i++) begin
        chk("tbl_issue_en", i, mem_en_o[i], 1'b1);
        chk("tbl_issue_addr", i, mem_addr_o[i], vecs[v].addr);
        chk("tbl_issue_we", i, mem_we_o[i], vecs[v].exp_mwe);
        chk("tbl_issue_mask", i, mem_wmask_o[i], vecs[v].exp_msk);
        chk("tbl_issue_wdata", i, mem_wdata_o[i], vecs[v].exp_mwd);
        ack_at[i] = -1;
      end
      for (int k = 2; k <= 7; k++) begin
        tick();
        for (int i = 0; i < 2; i++)
          if ((vecs[v].is_d ? d_ack_o[i] : if_ack_o[i]) && ack_at[i] < 0) ack_at[i] = k;
      end
      for (int i = 0; i < 2; i++) begin
        chk("tbl_ack_cycle", i, ack_at[i], lat(i) + 2);
        if (vecs[v].is_d) chk("tbl_d_rdata", i, d_rdata_o[i], vecs[v].exp_d);
        else chk("tbl_if_rdata", i, if_rdata_o[i], vecs[v].exp_if);
      end
    end

    // First tie after reset goes to data; fetch follows right after.
    nrst = 0; tick(); nrst = 1;
    if_req = 1; d_req = 1; d_we = 0; if_addr = 32'h40; d_addr = 32'h80;
    tick();
    d_req = 0;
    for (int i = 0; i < 2; i++) begin
      chk("tie_first_addr", i, mem_addr_o[i], 32'h80);
      chk("tie_first_en", i, mem_en_o[i], 1'b1);
      ack_at[i] = -1; iss_at[i] = -1; fack_at[i] = -1;
    end
    for (int k = 2; k <= 14; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (d_ack_o[i] && ack_at[i] < 0) ack_at[i] = k;
        if (mem_en_o[i] && mem_addr_o[i] == 32'h40 && iss_at[i] < 0) iss_at[i] = k;
        if (if_ack_o[i] && fack_at[i] < 0) fack_at[i] = k;
      end
    end
    for (int i = 0; i < 2; i++) begin
      chk("tie_d_ack", i, ack_at[i], lat(i) + 2);
      chk("tie_f_issue", i, iss_at[i], lat(i) + 4);
      chk("tie_f_ack", i, fack_at[i], 2 * lat(i) + 5);
    end
    if_req = 0;
    repeat (10) tick();

    // Both requesters held high: acks alternate d,f,d,... at the period.
    nrst = 0; tick(); nrst = 1;
    if_req = 1; d_req = 1;
    coinc = 0;
    for (int i = 0; i < 2; i++) begin n_ack[i] = 0; prev_k[i] = 0; prev_d[i] = 0; end
    tick();
    for (int k = 1; k <= 24; k++) begin
      if (k > 1) tick();
      for (int i = 0; i < 2; i++) begin
        if (if_ack_o[i] && d_ack_o[i]) coinc++;
        if (if_ack_o[i] || d_ack_o[i]) begin
          is_d_ack = d_ack_o[i];
          if (n_ack[i] == 0) chk("alt_first_is_data", i, is_d_ack, 1'b1);
          else begin
            chk("alt_owner_flips", i, is_d_ack, !prev_d[i]);
            chk("alt_period", i, k - prev_k[i], lat(i) + 3);
          end
          prev_d[i] = is_d_ack; prev_k[i] = k; n_ack[i]++;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      exp_n = 0;
      for (int k = lat(i) + 2; k <= 24; k += lat(i) + 3) exp_n++;
      chk("alt_ack_count", i, n_ack[i], exp_n);
    end
    chk("alt_no_coincide", 0, coinc, 0);
    if_req = 0; d_req = 0;
    repeat (12) tick();

    // Reset while the latency-3 instance waits on memory aborts silently.
    nrst = 0; tick(); nrst = 1;
    mem_rdata = 64'h11111111_22222222; if_req = 1; if_addr = 32'h4;
    tick();
    if_req = 0;
    tick(); tick();
    chk("rst_wait_busy", 1, busy_o[1], 1'b1);
    nrst = 0;
    tick();
    nrst = 1;
    chk("rst_if_ack", 1, if_ack_o[1], 1'b0);
    chk("rst_d_ack", 1, d_ack_o[1], 1'b0);
    chk("rst_if_rdata", 1, if_rdata_o[1], 32'h0);
    chk("rst_d_rdata", 1, d_rdata_o[1], 64'h0);
    chk("rst_mem_en", 1, mem_en_o[1], 1'b0);
    chk("rst_mem_we", 1, mem_we_o[1], 1'b0);
    chk("rst_mem_addr", 1, mem_addr_o[1], 32'h0);
    chk("rst_mem_wdata", 1, mem_wdata_o[1], 64'h0);
    chk("rst_mem_wmask", 1, mem_wmask_o[1], 8'h0);
    chk("rst_busy", 1, busy_o[1], 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_no_late_ack", 1, if_ack_o[1], 1'b0);
    end
    mem_rdata = 64'hFEEDFACE_0BADC0DE; if_req = 1; if_addr = 32'h4;
    tick();
    if_req = 0;
    ack_at[1] = -1;
    for (int k = 2; k <= 8; k++) begin
      tick();
      if (if_ack_o[1] && ack_at[1] < 0) ack_at[1] = k;
    end
    chk("post_rst_ack", 1, ack_at[1], 5);
    chk("post_rst_if_rdata", 1, if_rdata_o[1], 32'hFEEDFACE);

    // Random traffic against the reference model.
    rand_mem = 1;
    for (int k = 0; k < 2500; k++) begin
      nrst    = ($urandom_range(0, 79) != 0);
      if_req  = ($urandom_range(0, 2) != 0);
      d_req   = ($urandom_range(0, 2) != 0);
      d_we    = $urandom_range(0, 1);
      if_addr = $urandom;
      d_addr  = $urandom;
      d_wdata = {$urandom, $urandom};
      d_wmask = 8'($urandom);
      tick();
    end
    if_req = 0; d_req = 0; nrst = 1;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
